// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit frame sequencer.
package uart_tx_ctrl_pkg;

    localparam int unsigned TxWidth = 8;

    // Encodings are shared with the RX controller; keep the values stable.
    typedef enum logic [2:0] {
        TxIdle   = 3'd0,
        TxStart  = 3'd1,
        TxData   = 3'd2,
        TxParity = 3'd3,
        TxStop   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_parity.sv
// Parity bit for a transmit word: even (typ = 0) or odd (typ = 1).
module uart_tx_ctrl_parity #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_par_typ,
    output logic             o_par_bit
);

    assign o_par_bit = (^i_data) ^ i_par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start / data / optional parity / stop bits,
// one bit per clock, driving the serializer enable and the TX line.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = TxWidth
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_data_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_par_en,
    input  logic             i_par_typ,
    input  logic             i_ser_data,
    input  logic             i_ser_done,
    output logic             o_ser_en,
    output logic             o_busy,
    output logic             o_tx,
    output logic             o_frame_done
);

    tx_state_e r_state;
    logic      r_par_bit;
    logic      r_par_en;
    logic      r_busy;
    logic      r_frame_done;
    logic      w_par_bit;

    uart_tx_ctrl_parity #(
        .WIDTH(WIDTH)
    ) u_parity (
        .i_data   (i_data),
        .i_par_typ(i_par_typ),
        .o_par_bit(w_par_bit)
    );

    // Busy and frame-done are registered alongside the state they decode.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= TxIdle;
            r_par_bit    <= 1'b0;
            r_par_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                TxIdle: begin
                    if (i_data_valid) begin
                        r_state   <= TxStart;
                        r_par_bit <= w_par_bit;
                        r_par_en  <= i_par_en;
                        r_busy    <= 1'b1;
                    end
                end
                TxStart: r_state <= TxData;
                TxData: begin
                    if (i_ser_done) begin
                        if (r_par_en) begin
                            r_state <= TxParity;
                        end else begin
                            r_state      <= TxStop;
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                TxParity: begin
                    r_state      <= TxStop;
                    r_frame_done <= 1'b1;
                end
                TxStop: begin
                    r_state <= TxIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= TxIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Line mux: no path from i_data_valid, only state and serializer bit.
    always_comb begin
        o_tx     = 1'b1;
        o_ser_en = 1'b0;
        case (r_state)
            TxStart:  o_tx = 1'b0;
            TxData: begin
                o_tx     = i_ser_data;
                o_ser_en = 1'b1;
            end
            TxParity: o_tx = r_par_bit;
            default:  o_tx = 1'b1;
        endcase
    end

    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl with a behavioural serializer alongside.
module tb_uart_tx_ctrl;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic tx;
        logic busy;
        logic ser_en;
        logic done;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         data_valid = 1'b0;
    logic [W-1:0] data = '0;
    logic         par_en = 1'b0;
    logic         par_typ = 1'b0;
    logic         ser_data;
    logic         ser_done;
    logic         ser_en;
    logic         busy;
    logic         tx;
    logic         frame_done;

    logic [W-1:0] ser_sh = '0;
    logic [2:0]   ser_cnt = '0;

    obs_t exp_q[$];
    obs_t pend_q[$];
    bit   started = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .WIDTH(W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data_valid(data_valid),
        .i_data      (data),
        .i_par_en    (par_en),
        .i_par_typ   (par_typ),
        .i_ser_data  (ser_data),
        .i_ser_done  (ser_done),
        .o_ser_en    (ser_en),
        .o_busy      (busy),
        .o_tx        (tx),
        .o_frame_done(frame_done)
    );

    // Serializer: loads on an accepted request, shifts LSB first while enabled.
    always @(posedge clk) begin
        if (!rst) begin
            ser_cnt <= '0;
        end else if (data_valid && !busy) begin
            ser_sh  <= data;
            ser_cnt <= '0;
        end else if (ser_en) begin
            ser_sh  <= ser_sh >> 1;
            ser_cnt <= ser_cnt + 3'd1;
        end
    end
    assign ser_data = ser_sh[0];
    assign ser_done = (ser_cnt == 3'(W - 1));

    function automatic obs_t mk(input logic t, input logic b, input logic e, input logic d);
        obs_t o;
        o.tx = t;
        o.busy = b;
        o.ser_en = e;
        o.done = d;
        return o;
    endfunction

    // Whole-frame expectation: start, data LSB first, optional parity, stop,
    // then the mandatory idle cycle before another request can be taken.
    function automatic void build_frame(input logic [W-1:0] d, input logic pe, input logic pt);
        int ones;
        ones = $countones(d);
        pend_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < int'(W); i++) pend_q.push_back(mk(d[i], 1'b1, 1'b1, 1'b0));
        if (pe) pend_q.push_back(mk(logic'(ones % 2) ^ pt, 1'b1, 1'b0, 1'b0));
        pend_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1));
        pend_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
    endfunction

    // Reference model: decides, from stimulus alone, what the next cycle shows.
    always @(posedge clk) begin
        obs_t nxt;
        if (!rst) begin
            pend_q.delete();
            nxt = mk(1'b1, 1'b0, 1'b0, 1'b0);
        end else if (pend_q.size() != 0) begin
            nxt = pend_q.pop_front();
        end else if (data_valid) begin
            build_frame(data, par_en, par_typ);
            nxt = pend_q.pop_front();
        end else begin
            nxt = mk(1'b1, 1'b0, 1'b0, 1'b0);
        end
        exp_q.push_back(nxt);
        started = 1'b1;
    end

    // Monitor: every cycle the DUT presents one observation to check.
    always @(negedge clk) begin
        obs_t e;
        obs_t got;
        if (started) begin
            cyc++;
            n_vec++;
            got = mk(tx, busy, ser_en, frame_done);
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty cycle %0d got tx/busy/en/done=%b required an entry",
                         cyc, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL line_obs cycle %0d tx/busy/en/done got %b required %b",
                             cyc, got, e);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic pe, input logic pt, input int gap);
        data_valid = 1'b1;
        data = d;
        par_en = pe;
        par_typ = pt;
        step(1);
        data_valid = 1'b0;
        step(gap);
    endtask

    initial begin
        step(3);
        rst = 1'b1;
        step(2);

        send(8'hA5, 1'b0, 1'b0, 12);
        send(8'hA5, 1'b1, 1'b1, 13);
        send(8'h01, 1'b1, 1'b0, 13);

        // Held request: second word presented mid-frame must wait its turn.
        data_valid = 1'b1;
        data = 8'h3C;
        par_en = 1'b0;
        step(1);
        data = 8'hC3;
        step(12);
        data_valid = 1'b0;
        step(12);

        // Reset pulse in the middle of the data bits, then a clean frame.
        send(8'h5A, 1'b1, 1'b0, 5);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(2);
        send(8'h96, 1'b1, 1'b1, 13);

        // Configuration toggled while the frame is in flight.
        send(8'h7E, 1'b1, 1'b0, 0);
        for (int i = 0; i < 12; i++) begin
            par_en = ~par_en;
            par_typ = ~par_typ;
            data = W'($urandom);
            step(1);
        end
        par_en = 1'b0;
        step(3);

        for (int i = 0; i < 2000; i++) begin
            data_valid = ($urandom_range(0, 3) != 0);
            data = W'($urandom);
            par_en = 1'($urandom);
            par_typ = 1'($urandom);
            rst = ($urandom_range(0, 199) != 0);
            step(1);
        end
        rst = 1'b1;
        data_valid = 1'b0;
        step(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
